core_sequencer: RTL and testbench
=================================

# core_sequencer

Multi-cycle sequencer for the instruction execution unit. Owns the program counter, fetches each instruction over a single shared memory port, holds it stable while the combinational execution datapath evaluates, and drives load/store traffic on the same port. It also issues the one-cycle commit strobe that gates register-file writes. It sits between the execution unit and the memory subsystem, replacing free-running single-cycle operation.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- MAX_WAIT, 16, cycles a memory request may stay un-acknowledged before the fault state is entered (1..255)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- mem_req  out  1  memory request, held until acknowledged
- mem_we  out  1  1 = write (store), 0 = read
- mem_addr  out  32  byte address
- mem_wdata  out  32  store data
- mem_rdata  in  32  read data, valid when mem_ready=1
- mem_ready  in  1  acknowledge; completes the request in the same cycle
- instr  out  32  registered instruction to the execution unit
- pc  out  32  registered PC to the execution unit
- mem_data  out  32  registered load data to the execution unit
- alu_result  in  32  execution-unit ALU result (address or branch/jump target)
- reg_data_2  in  32  execution-unit rs2 value (store data)
- pc_src  in  1  1 = next PC is alu_result
- exec_en  out  1  commit strobe: register-file write enable gate, one cycle per instruction
- retired  out  32  count of committed instructions, wraps
- fault  out  1  sticky, memory timeout

## Operation
- States: FETCH, EXEC, MEM, WB, HALT.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. When mem_ready=1, instr<=mem_rdata and go to EXEC.
- EXEC: instr and pc are stable, and the datapath evaluates combinationally. Decode instr[6:0]:
  - Load (7'b0000011) or store (7'b0100011): go to MEM.
  - Otherwise: exec_en=1, pc<=pc_src ? alu_result : pc+4, retired++, go to FETCH.
- MEM: mem_req=1, mem_addr=alu_result, mem_we=1 for store, mem_wdata=reg_data_2. On mem_ready=1:
  - For a load, mem_data<=mem_rdata (a store leaves mem_data unchanged).
  - Go to WB.
- WB: exec_en=1, pc<=pc+4, retired++, go to FETCH.
- Wait counter: cleared on every entry to FETCH or MEM. Increments each cycle that mem_req=1 and mem_ready=0. If it reaches MAX_WAIT with mem_ready still 0, go to HALT and set fault=1.
- HALT: mem_req=0, exec_en=0. The block stays here until rst.
- mem_req, mem_we, mem_addr, mem_wdata and exec_en are Moore outputs, decoded from state plus held registers and inputs only.
- Outside MEM: mem_we=0 and mem_wdata=0. Outside FETCH and MEM: mem_addr=pc.
- PC arithmetic is 32-bit modulo: pc+4 wraps from 32'hFFFF_FFFC to 0. alu_result is used unaligned and unmodified.
- retired wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset (rst=1 at a rising edge): state=FETCH, pc=RESET_PC, instr=32'h0000_0013 (NOP), mem_data=0, retired=0, fault=0, wait counter=0.
- The first cycle after reset already drives mem_req=1 with mem_addr=RESET_PC.
- rst takes priority over every transition. Reset during MEM drops the outstanding request on the next cycle, and no commit occurs.
- Latency with zero wait states (mem_ready=1 in the first request cycle):
  - ALU, branch and jump instructions: 2 cycles.
  - Loads and stores: 4 cycles.
  - Each wait cycle adds 1.
- Handshake: while mem_req=1 and mem_ready=0, mem_addr, mem_we and mem_wdata are held constant. mem_ready while mem_req=0 is ignored.
- exec_en is high for exactly one cycle per instruction, and pc updates on the same edge that ends that cycle.
- In WB, instr and mem_data are still stable, so a load writes its loaded data.
- A timeout is detected on the edge where the counter equals MAX_WAIT. fault is visible the cycle after.

## Test plan
- Reset then addi (32'h00500093) at 0, zero-wait memory: mem_req at addr 0 in cycle 1, exec_en in cycle 2, pc=4, retired=1.
- Branch with pc_src=1, alu_result=32'h40: pc=32'h40 after exec_en. With pc_src=0: pc=pc+4.
- Load (lw x1,0(x2)), alu_result=32'h100, mem_rdata=32'hDEADBEEF, 3 wait states in MEM:
  - mem_addr=32'h100 held for 4 cycles with mem_we=0.
  - mem_data=32'hDEADBEEF during WB.
  - Total 7 cycles.
- Store (sw), reg_data_2=32'hCAFE0001, alu_result=32'h200: one MEM cycle with mem_we=1, mem_wdata=32'hCAFE0001, then WB with exec_en=1.
- mem_ready held 0 during FETCH with MAX_WAIT=4: state HALT, fault=1, mem_req=0, and no exec_en from then on. Asserting rst clears fault and restarts the fetch at RESET_PC.
- Wrap cases: pc=32'hFFFF_FFFC with a non-branch instruction gives pc=0; retired preloaded near 32'hFFFF_FFFF wraps to 0. Also assert rst during MEM: no exec_en, pc=RESET_PC.

Source files
------------

// File: rtl/core_sequencer.sv
// Multi-cycle sequencer for the execution unit. It owns the PC, fetches over a
// shared memory port, sequences load/store traffic and issues the commit strobe.
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] mem_data,
  input  logic [31:0] alu_result,
  input  logic [31:0] reg_data_2,
  input  logic        pc_src,
  output logic        exec_en,
  output logic [31:0] retired,
  output logic        fault
);

  localparam logic [7:0]  WAIT_LIMIT = 8'(MAX_WAIT);
  localparam logic [6:0]  OP_LOAD    = 7'b0000011;
  localparam logic [6:0]  OP_STORE   = 7'b0100011;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, HALT} state_t;

  state_t     state, state_next;
  logic [7:0] wait_cnt;
  logic       is_load, is_store, is_mem;
  logic       stall, timeout;

  assign is_load  = (instr[6:0] == OP_LOAD);
  assign is_store = (instr[6:0] == OP_STORE);
  assign is_mem   = is_load || is_store;
  assign stall    = mem_req && !mem_ready;
  // MAX_WAIT stall cycles are tolerated; the next stall at the limit faults.
  assign timeout  = stall && (wait_cnt == WAIT_LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      FETCH: if (mem_ready) state_next = EXEC;
             else if (timeout) state_next = HALT;
      EXEC:  state_next = is_mem ? MEM : FETCH;
      MEM:   if (mem_ready) state_next = WB;
             else if (timeout) state_next = HALT;
      WB:    state_next = FETCH;
      HALT:  state_next = HALT;
      default: state_next = HALT;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc;
    mem_wdata = 32'h0;
    exec_en   = 1'b0;
    unique case (state)
      FETCH: mem_req = 1'b1;
      EXEC:  exec_en = !is_mem;
      MEM: begin
        mem_req   = 1'b1;
        mem_we    = is_store;
        mem_addr  = alu_result;
        mem_wdata = reg_data_2;
      end
      WB:      exec_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      instr    <= NOP;
      mem_data <= 32'h0;
      retired  <= 32'h0;
      fault    <= 1'b0;
      wait_cnt <= 8'h0;
    end else begin
      if (state == FETCH && mem_ready) instr <= mem_rdata;
      if (state == MEM && mem_ready && is_load) mem_data <= mem_rdata;

      if (exec_en) begin
        pc      <= (state == EXEC && pc_src) ? alu_result : pc + 32'd4;
        retired <= retired + 32'd1;
      end

      // Any state change starts a fresh wait window for the next request.
      if (state_next != state) wait_cnt <= 8'h0;
      else if (stall)          wait_cnt <= wait_cnt + 8'd1;

      if (state_next == HALT) fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed cases plus randomized
// instruction streams compared against a per-instruction reference model.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, mem_ready, pc_src, exec_en, fault;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, instr, pc, mem_data;
  logic [31:0] alu_result, reg_data_2, retired;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_pc, exp_ret, exp_md;

  localparam logic [31:0] W_ADDI = 32'h0050_0093;
  localparam logic [31:0] W_ADD  = 32'h0020_81B3;
  localparam logic [31:0] W_BEQ  = 32'h0020_8463;
  localparam logic [31:0] W_JAL  = 32'h0080_00EF;
  localparam logic [31:0] W_LW   = 32'h0001_2083;
  localparam logic [31:0] W_SW   = 32'h0020_A023;

  core_sequencer #(.RESET_PC(32'h0), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .instr(instr), .pc(pc), .mem_data(mem_data),
    .alu_result(alu_result), .reg_data_2(reg_data_2), .pc_src(pc_src),
    .exec_en(exec_en), .retired(retired), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Executes one instruction end to end; the DUT must be in its fetch cycle.
  task automatic run_instr(input logic [31:0] word, input logic src,
                           input logic [31:0] alu, input logic [31:0] rs2,
                           input logic [31:0] rdata, input int fw, input int mw);
    logic [6:0] op;
    logic       ld, st;
    op = word[6:0];
    ld = (op == 7'b0000011);
    st = (op == 7'b0100011);
    pc_src = 1'b0;
    for (int i = 0; i <= fw; i++) begin
      mem_ready = (i == fw);
      mem_rdata = (i == fw) ? word : $urandom;
      #1;
      check1("fetch_req", mem_req, 1'b1);
      check1("fetch_we", mem_we, 1'b0);
      check32("fetch_addr", mem_addr, exp_pc);
      check1("fetch_commit", exec_en, 1'b0);
      tick();
    end
    mem_ready  = 1'($urandom_range(0, 1));
    mem_rdata  = $urandom;
    pc_src     = src;
    alu_result = alu;
    reg_data_2 = rs2;
    #1;
    check32("exec_instr", instr, word);
    check32("exec_pc", pc, exp_pc);
    check1("exec_req", mem_req, 1'b0);
    check32("exec_wdata", mem_wdata, 32'h0);
    if (!(ld || st)) begin
      check1("exec_commit", exec_en, 1'b1);
      tick();
      exp_pc  = src ? alu : exp_pc + 32'd4;
      exp_ret = exp_ret + 32'd1;
    end else begin
      check1("exec_nocommit", exec_en, 1'b0);
      tick();
      for (int j = 0; j <= mw; j++) begin
        mem_ready = (j == mw);
        mem_rdata = (j == mw) ? rdata : $urandom;
        #1;
        check1("mem_req", mem_req, 1'b1);
        check32("mem_addr", mem_addr, alu);
        check1("mem_we", mem_we, st);
        check32("mem_wdata", mem_wdata, rs2);
        check1("mem_commit", exec_en, 1'b0);
        tick();
      end
      if (ld) exp_md = rdata;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      #1;
      check1("wb_commit", exec_en, 1'b1);
      check1("wb_req", mem_req, 1'b0);
      check32("wb_mem_data", mem_data, exp_md);
      check32("wb_instr", instr, word);
      tick();
      exp_pc  = exp_pc + 32'd4;
      exp_ret = exp_ret + 32'd1;
    end
    check32("post_pc", pc, exp_pc);
    check32("post_retired", retired, exp_ret);
    check1("post_fault", fault, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    tick();
    rst = 1'b0;
    exp_pc  = 32'h0;
    exp_ret = 32'h0;
    exp_md  = 32'h0;
  endtask

  initial begin
    logic [31:0] rnd, word;
    logic [6:0]  ops [6];
    ops[0] = 7'b0010011; ops[1] = 7'b0110011; ops[2] = 7'b1100011;
    ops[3] = 7'b1101111; ops[4] = 7'b0000011; ops[5] = 7'b0100011;

    rst = 1'b1; mem_ready = 1'b0; mem_rdata = 32'h0; pc_src = 1'b0;
    alu_result = 32'h0; reg_data_2 = 32'h0;
    tick();
    do_reset();
    #1;
    check32("rst_pc", pc, 32'h0);
    check32("rst_instr", instr, 32'h0000_0013);
    check32("rst_mem_data", mem_data, 32'h0);
    check32("rst_retired", retired, 32'h0);
    check1("rst_fault", fault, 1'b0);
    check1("rst_req", mem_req, 1'b1);
    check32("rst_addr", mem_addr, 32'h0);

    run_instr(W_ADDI, 1'b0, 32'h5, 32'h0, 32'h0, 0, 0);
    run_instr(W_BEQ, 1'b1, 32'h40, 32'h0, 32'h0, 0, 0);
    run_instr(W_BEQ, 1'b0, 32'h1234, 32'h0, 32'h0, 1, 0);
    run_instr(W_LW, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 3);
    run_instr(W_SW, 1'b1, 32'h200, 32'hCAFE_0001, 32'h0, 0, 0);
    run_instr(W_ADD, 1'b0, 32'h0, 32'h0, 32'h0, 4, 0);
    run_instr(W_LW, 1'b0, 32'h300, 32'h0, 32'h1357_9BDF, 2, 4);
    run_instr(W_JAL, 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0);
    run_instr(W_ADDI, 1'b0, 32'h9, 32'h0, 32'h0, 0, 0);
    check32("pc_wrap", pc, 32'h0);

    for (int n = 0; n < 60; n++) begin
      rnd  = $urandom;
      word = {rnd[31:7], ops[$urandom_range(0, 5)]};
      run_instr(word, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset while a load sits stalled in its memory phase.
    mem_ready = 1'b1; mem_rdata = W_LW;
    tick();
    mem_ready = 1'b0; alu_result = 32'h500;
    tick();
    #1;
    check1("mid_mem_req", mem_req, 1'b1);
    check32("mid_mem_addr", mem_addr, 32'h500);
    do_reset();
    #1;
    check1("mid_rst_commit", exec_en, 1'b0);
    check32("mid_rst_pc", pc, 32'h0);
    check32("mid_rst_retired", retired, 32'h0);
    check1("mid_rst_req", mem_req, 1'b1);
    check32("mid_rst_addr", mem_addr, 32'h0);
    check1("mid_rst_we", mem_we, 1'b0);

    // Fetch timeout with MAX_WAIT=4: five stalled request cycles, then HALT.
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check1("to_req", mem_req, 1'b1);
      check1("to_fault_pre", fault, 1'b0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      check1("halt_req", mem_req, 1'b0);
      check1("halt_fault", fault, 1'b1);
      check1("halt_commit", exec_en, 1'b0);
      tick();
    end
    do_reset();
    #1;
    check1("rec_fault", fault, 1'b0);
    check1("rec_req", mem_req, 1'b1);
    check32("rec_addr", mem_addr, 32'h0);
    run_instr(W_ADDI, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
